spi_flash_responder: RTL and testbench

SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

---
 rtl/spi_flash_responder.sv | 177 +++++++++++++++++
 tb/tb_spi_flash_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_responder.sv
// SPI NOR flash read responder: 0x03 READ and 0x9F JEDEC ID, one-byte prefetch from a byte memory port.
// Define FAST_READ_EN to also accept 0x0B FAST READ (24-bit address + 8 dummy clocks).
module spi_flash_responder #(
  parameter int          ADDR_W   = 24,
  parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flash_clk,
  input  logic              flash_csn,
  input  logic              flash_io0_in,
  output logic              flash_io1_out,
  output logic              flash_io1_en,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [7:0]        mem_rdata,
  output logic              underrun
);
  localparam logic [2:0] S_IDLE = 3'd0, S_CMD = 3'd1, S_ADDR = 3'd2, S_DUMMY = 3'd3,
                         S_DATA = 3'd4, S_ID = 3'd5, S_IGNORE = 3'd6;
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  logic [1:0]        sclk_q, csn_q, mosi_q;
  logic              sclk_prev_q, csn_prev_q, armed_q;
  logic [1:0]        settle_q, id_idx_q;
  logic [2:0]        state_q, state_d;
  logic [4:0]        bcnt_q;
  logic [22:0]       sh_in_q;
  logic [7:0]        sh_out_q, pf_data_q, load_byte;
  logic [ADDR_W-1:0] cur_addr_q, mem_addr_q;
  logic              need_q, discard_q, pf_full_q, io1_q, en_q, mem_valid_q, underrun_q;
`ifdef FAST_READ_EN
  logic              fast_q;
`endif

  logic       csn_s, mosi_s, sclk_rise, sclk_fall, csn_fall, csn_rise, mem_done, pf_avail;
  logic [7:0] cmd_w, pf_byte;
  assign csn_s     = csn_q[1];
  assign mosi_s    = mosi_q[1];
  assign sclk_rise = sclk_q[1] & ~sclk_prev_q & ~csn_s;
  assign sclk_fall = ~sclk_q[1] & sclk_prev_q & ~csn_s;
  // armed_q blocks a CMD start until csn has been seen high since reset
  assign csn_fall  = ~csn_s & csn_prev_q & armed_q;
  assign csn_rise  = csn_s & ~csn_prev_q;
  assign cmd_w     = {sh_in_q[6:0], mosi_s};
  assign mem_done  = mem_valid_q & mem_ready;
  assign pf_avail  = pf_full_q | (mem_done & ~discard_q);
  assign pf_byte   = pf_full_q ? pf_data_q : mem_rdata;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (csn_fall) state_d = S_CMD;
      S_CMD:   if (sclk_rise && bcnt_q == 5'd7) begin
        if (cmd_w == 8'h03)      state_d = S_ADDR;
        else if (cmd_w == 8'h9F) state_d = S_ID;
`ifdef FAST_READ_EN
        else if (cmd_w == 8'h0B) state_d = S_ADDR;
`endif
        else                     state_d = S_IGNORE;
      end
      S_ADDR:  if (sclk_rise && bcnt_q == 5'd23) begin
`ifdef FAST_READ_EN
        state_d = fast_q ? S_DUMMY : S_DATA;
`else
        state_d = S_DATA;
`endif
      end
      S_DUMMY: if (sclk_rise && bcnt_q == 5'd7) state_d = S_DATA;
      default: ;
    endcase
    if (csn_rise) state_d = S_IDLE;
  end

  always_comb begin
    load_byte = 8'hFF;
    if (state_q == S_ID) begin
      case (id_idx_q)
        2'd0:    load_byte = JEDEC_ID[23:16];
        2'd1:    load_byte = JEDEC_ID[15:8];
        2'd2:    load_byte = JEDEC_ID[7:0];
        default: load_byte = 8'hFF;
      endcase
    end else if (pf_avail) begin
      load_byte = pf_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sclk_q <= 2'b00; csn_q <= 2'b11; mosi_q <= 2'b00;
      sclk_prev_q <= 1'b0; csn_prev_q <= 1'b1; armed_q <= 1'b0; settle_q <= 2'd0;
      state_q <= S_IDLE; bcnt_q <= '0; sh_in_q <= '0; sh_out_q <= 8'hFF;
      id_idx_q <= 2'd0; pf_data_q <= '0; cur_addr_q <= '0; mem_addr_q <= '0;
      need_q <= 1'b0; discard_q <= 1'b0; pf_full_q <= 1'b0;
      io1_q <= 1'b1; en_q <= 1'b0; mem_valid_q <= 1'b0; underrun_q <= 1'b0;
`ifdef FAST_READ_EN
      fast_q <= 1'b0;
`endif
    end else begin
      sclk_q <= {sclk_q[0], flash_clk};
      csn_q  <= {csn_q[0], flash_csn};
      mosi_q <= {mosi_q[0], flash_io0_in};
      sclk_prev_q <= sclk_q[1];
      csn_prev_q  <= csn_s;
      if (settle_q != 2'd2) settle_q <= settle_q + 2'd1;
      if (settle_q == 2'd2 && csn_s) armed_q <= 1'b1;
      state_q    <= state_d;
      en_q       <= (state_d == S_DATA) || (state_d == S_ID);
      underrun_q <= 1'b0;

      if (mem_done) begin
        mem_valid_q <= 1'b0;
        if (discard_q) discard_q <= 1'b0;
        else begin
          pf_full_q <= 1'b1;
          pf_data_q <= mem_rdata;
        end
      end else if (need_q && !mem_valid_q && !sclk_fall && !csn_rise) begin
        mem_valid_q <= 1'b1;
        mem_addr_q  <= cur_addr_q;
        need_q      <= 1'b0;
      end

      if (sclk_rise && (state_q == S_CMD || state_q == S_ADDR || state_q == S_DUMMY)) begin
        sh_in_q <= {sh_in_q[21:0], mosi_s};
        bcnt_q  <= bcnt_q + 5'd1;
      end
      if (state_q == S_ADDR && sclk_rise && bcnt_q == 5'd23) begin
        cur_addr_q <= ADDR_W'({sh_in_q, mosi_s});
        need_q     <= 1'b1;
      end

      if (sclk_fall && (state_q == S_DATA || state_q == S_ID)) begin
        bcnt_q <= bcnt_q + 5'd1;
        if (bcnt_q[2:0] == 3'd0) begin
          io1_q    <= load_byte[7];
          sh_out_q <= {load_byte[6:0], 1'b1};
          if (state_q == S_ID) begin
            if (id_idx_q != 2'd3) id_idx_q <= id_idx_q + 2'd1;
          end else begin
            // A late byte is dropped so byte positions stay aligned with addresses
            cur_addr_q <= cur_addr_q + ONE;
            need_q     <= 1'b1;
            if (pf_avail) pf_full_q <= 1'b0;
            else begin
              underrun_q <= 1'b1;
              if (mem_valid_q && !mem_ready) discard_q <= 1'b1;
            end
          end
        end else begin
          io1_q    <= sh_out_q[7];
          sh_out_q <= {sh_out_q[6:0], 1'b1};
        end
      end

      if (state_d != state_q) bcnt_q <= '0;
`ifdef FAST_READ_EN
      if (state_q == S_CMD && state_d == S_ADDR) fast_q <= (cmd_w == 8'h0B);
`endif
      if (csn_rise) begin
        io1_q     <= 1'b1;
        pf_full_q <= 1'b0;
        need_q    <= 1'b0;
        id_idx_q  <= 2'd0;
        if (mem_valid_q && !mem_ready) discard_q <= 1'b1;
      end
    end
  end

  assign flash_io1_out = io1_q;
  assign flash_io1_en  = en_q;
  assign mem_valid     = mem_valid_q;
  assign mem_addr      = mem_addr_q;
  assign underrun      = underrun_q;
endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboard bench for spi_flash_responder: expected mem addresses and MISO bytes are queued by
// the stimulus and popped by independent mem-port and SPI monitors.
module tb_spi_flash_responder;
  logic        clk, reset_n, fclk, csn, csn8, mosi;
  logic        miso, miso_en, mem_valid, mem_ready, underrun;
  logic [23:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        miso8, miso_en8, mem_valid8, mem_ready8, underrun8;
  logic [7:0]  mem_addr8, mem_rdata8;

  int          n_tests, n_fail, delay_next, ur_cnt, en_hi, ur0, en0;
  logic [31:0] exp_addr[$], exp_addr8[$];
  logic [7:0]  exp_miso[$];
  logic [7:0]  mem[256];

  spi_flash_responder dut (
    .clk(clk), .reset_n(reset_n), .flash_clk(fclk), .flash_csn(csn), .flash_io0_in(mosi),
    .flash_io1_out(miso), .flash_io1_en(miso_en), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .underrun(underrun));

  spi_flash_responder #(.ADDR_W(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .flash_clk(fclk), .flash_csn(csn8), .flash_io0_in(mosi),
    .flash_io1_out(miso8), .flash_io1_en(miso_en8), .mem_valid(mem_valid8), .mem_addr(mem_addr8),
    .mem_ready(mem_ready8), .mem_rdata(mem_rdata8), .underrun(underrun8));

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Memory-port monitor/responder for the 24-bit instance
  initial begin : mem_mon
    int d;
    logic [23:0] a;
    logic [31:0] e;
    mem_ready = 1'b0; mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (mem_valid) begin
        a = mem_addr;
        e = (exp_addr.size() != 0) ? exp_addr.pop_front() : 32'hFFFF_FFFF;
        chk("mem_addr", {8'h00, a}, e);
        d = delay_next; delay_next = 0;
        repeat (d) @(negedge clk);
        mem_rdata = mem[a[7:0]]; mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
      end
    end
  end

  initial begin : mem8_mon
    logic [31:0] e;
    mem_ready8 = 1'b0; mem_rdata8 = 8'h00;
    forever begin
      @(negedge clk);
      if (mem_valid8) begin
        e = (exp_addr8.size() != 0) ? exp_addr8.pop_front() : 32'hFFFF_FFFF;
        chk("mem_addr8", {24'h0, mem_addr8}, e);
        mem_rdata8 = mem[mem_addr8]; mem_ready8 = 1'b1;
        @(negedge clk);
        mem_ready8 = 1'b0;
      end
    end
  end

  // SPI-side monitor: initiator samples MISO on rising flash_clk while enabled
  initial begin : miso_mon
    int nb;
    logic [7:0] sh, e;
    nb = 0; sh = 8'h00;
    forever begin
      @(posedge fclk or posedge csn);
      if (csn) nb = 0;
      else if (miso_en) begin
        sh = {sh[6:0], miso}; nb++;
        if (nb == 8) begin
          nb = 0;
          e = (exp_miso.size() != 0) ? exp_miso.pop_front() : 8'hXX;
          chk("miso_byte", {24'h0, sh}, {24'h0, e});
        end
      end
    end
  end

  initial begin : counters
    ur_cnt = 0; en_hi = 0;
    forever begin
      @(negedge clk);
      if (underrun) ur_cnt++;
      if (miso_en) en_hi++;
    end
  end

  task automatic bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = v[i];
      #80 fclk = 1'b1;
      #80 fclk = 1'b0;
    end
  endtask

  task automatic cs_low(input bit use8);
    @(negedge clk);
    if (use8) csn8 = 1'b0; else csn = 1'b0;
    #80;
  endtask

  task automatic cs_high();
    #80 csn = 1'b1; csn8 = 1'b1;
    #400;
  endtask

  task automatic data_clocks(input int nbytes);
    for (int i = 0; i < nbytes; i++) bits(32'h0, 8);
  endtask

  task automatic drained(input string nm);
    chk({nm, "_addr_left"}, exp_addr.size(), 0);
    chk({nm, "_miso_left"}, exp_miso.size(), 0);
  endtask

  initial begin : stim
    n_tests = 0; n_fail = 0; delay_next = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'h10] = 8'hA5; mem[8'h11] = 8'h3C;
    reset_n = 1'b0; fclk = 1'b0; csn = 1'b1; csn8 = 1'b1; mosi = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_miso", miso, 1'b1);
    chk("rst_en", miso_en, 1'b0);
    chk("rst_valid", mem_valid, 1'b0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_underrun", underrun, 1'b0);
    chk("rst8_miso_en_ur", {miso8, miso_en8, underrun8}, 3'b100);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // Plain read of two bytes; the trailing falling edge loads a third
    ur0 = ur_cnt;
    exp_addr.push_back(32'h10); exp_addr.push_back(32'h11); exp_addr.push_back(32'h12);
    exp_addr.push_back(32'h13);
    exp_miso.push_back(8'hA5); exp_miso.push_back(8'h3C);
    cs_low(0); bits(32'h03, 8); bits(32'h000010, 24); data_clocks(2); cs_high();
    drained("read"); chk("read_underrun", ur_cnt - ur0, 0);

    // JEDEC ID, then 0xFF filler
    exp_miso.push_back(8'hEF); exp_miso.push_back(8'h40); exp_miso.push_back(8'h16);
    exp_miso.push_back(8'hFF); exp_miso.push_back(8'hFF);
    cs_low(0); bits(32'h9F, 8); data_clocks(5); cs_high();
    drained("id");

    // Late first byte: 0xFF plus one underrun, later bytes stay address-aligned
    ur0 = ur_cnt; delay_next = 64;
    exp_addr.push_back(32'h30); exp_addr.push_back(32'h31); exp_addr.push_back(32'h32);
    exp_addr.push_back(32'h33); exp_addr.push_back(32'h34);
    exp_miso.push_back(8'hFF); exp_miso.push_back(8'h6B); exp_miso.push_back(8'h68);
    cs_low(0); bits(32'h03, 8); bits(32'h000030, 24); data_clocks(3); cs_high();
    drained("late"); chk("late_underrun", ur_cnt - ur0, 1);

    // Abort inside the address phase, then a clean read at 0x20
    cs_low(0); bits(32'h03, 8); bits(32'h000, 12); cs_high();
    exp_addr.push_back(32'h20); exp_addr.push_back(32'h21); exp_addr.push_back(32'h22);
    exp_miso.push_back(8'h7A);
    cs_low(0); bits(32'h03, 8); bits(32'h000020, 24); data_clocks(1); cs_high();
    drained("abort12");

    // Abort with a request still outstanding: its data must not leak into the next read
    ur0 = ur_cnt; delay_next = 150;
    exp_addr.push_back(32'h50);
    cs_low(0); bits(32'h03, 8); bits(32'h000050, 24); cs_high();
    exp_addr.push_back(32'h60); exp_addr.push_back(32'h61); exp_addr.push_back(32'h62);
    exp_miso.push_back(8'h3A);
    cs_low(0); bits(32'h03, 8); bits(32'h000060, 24); data_clocks(1); cs_high();
    drained("discard"); chk("discard_underrun", ur_cnt - ur0, 1);

    // FAST READ
    ur0 = ur_cnt; en0 = en_hi;
`ifdef FAST_READ_EN
    exp_addr.push_back(32'h04); exp_addr.push_back(32'h05); exp_addr.push_back(32'h06);
    exp_miso.push_back(8'h5E);
    cs_low(0); bits(32'h0B, 8); bits(32'h000004, 24); bits(32'h0, 8); data_clocks(1); cs_high();
    drained("fast");
`else
    cs_low(0); bits(32'h0B, 8); bits(32'h000004, 24); bits(32'h0, 8); data_clocks(1); cs_high();
    drained("fast_off"); chk("fast_off_en_cycles", en_hi - en0, 0);
`endif
    chk("fast_underrun", ur_cnt - ur0, 0);

    // 8-bit address instance: 0xFFFFFF wraps to 0x00
    exp_addr8.push_back(32'hFF); exp_addr8.push_back(32'h00); exp_addr8.push_back(32'h01);
    exp_addr8.push_back(32'h02);
    cs_low(1); bits(32'h03, 8); bits(32'hFFFFFF, 24); data_clocks(2); cs_high();
    chk("wrap8_addr_left", exp_addr8.size(), 0);

    // Reset mid-transaction: ignored until csn returns high
    cs_low(0); bits(32'h03, 8); bits(32'h00, 8);
    @(negedge clk); reset_n = 1'b0;
    repeat (3) @(negedge clk); reset_n = 1'b1;
    en0 = en_hi;
    bits(32'h9F, 8); data_clocks(2);
    chk("rst_mid_en_cycles", en_hi - en0, 0);
    cs_high();
    exp_miso.push_back(8'hEF); exp_miso.push_back(8'h40); exp_miso.push_back(8'h16);
    cs_low(0); bits(32'h9F, 8); data_clocks(3); cs_high();
    drained("rst_mid");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
